// File: rtl/wt_8b_pkg.sv
//------------------------------------------------------------------------------
// Module  : wt_8b_pkg
// Brief   : Width constants shared by the 8x8 Wallace-tree multiplier.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package wt_8b_pkg;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
endpackage

`default_nettype wire

// File: rtl/wt_8b_full_adder.sv
//------------------------------------------------------------------------------
// Module  : full_adder
// Brief   : Single-bit 3:2 compressor used for every carry-save cell.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

`default_nettype wire

// File: rtl/wt_8b.sv
//------------------------------------------------------------------------------
// Module  : wt_8b
// Brief   : 8x8 unsigned Wallace-tree multiplier, product registered once.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wt_8b
  import wt_8b_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   in0,
  input  logic [OP_W-1:0]   in1,
  output logic [PROD_W-1:0] out0
);

  logic [PROD_W-1:0] w_pp [8];
  logic [PROD_W-1:0] w_s1 [6];
  logic [PROD_W-1:0] w_s2 [4];
  logic [PROD_W-1:0] w_s3 [3];
  logic [PROD_W-1:0] w_s4 [2];
  logic [PROD_W-1:0] out0_d;
  logic [PROD_W-1:0] out0_q;

  for (genvar i = 0; i < OP_W; i++) begin : g_pp
    assign w_pp[i] = {{(PROD_W-OP_W){1'b0}}, in0 & {OP_W{in1[i]}}} << i;
  end

  // Rows are reduced in triples; the carry out of the top column always
  // lands above bit 15 and is never needed since the product fits 16 bits.
  for (genvar g = 0; g < 2; g++) begin : g_s1
    logic [PROD_W-1:0] sum;
    logic [PROD_W-2:0] cy;
    for (genvar k = 0; k < PROD_W; k++) begin : g_col
      if (k < PROD_W-1) begin : g_fa
        full_adder u_fa (
          .a    (w_pp[3*g][k]),
          .b    (w_pp[3*g+1][k]),
          .cin  (w_pp[3*g+2][k]),
          .sum  (sum[k]),
          .cout (cy[k])
        );
      end else begin : g_msb
        assign sum[k] = w_pp[3*g][k] ^ w_pp[3*g+1][k] ^ w_pp[3*g+2][k];
      end
    end
    assign w_s1[2*g]   = sum;
    assign w_s1[2*g+1] = {cy, 1'b0};
  end
  assign w_s1[4] = w_pp[6];
  assign w_s1[5] = w_pp[7];

  for (genvar g = 0; g < 2; g++) begin : g_s2
    logic [PROD_W-1:0] sum;
    logic [PROD_W-2:0] cy;
    for (genvar k = 0; k < PROD_W; k++) begin : g_col
      if (k < PROD_W-1) begin : g_fa
        full_adder u_fa (
          .a    (w_s1[3*g][k]),
          .b    (w_s1[3*g+1][k]),
          .cin  (w_s1[3*g+2][k]),
          .sum  (sum[k]),
          .cout (cy[k])
        );
      end else begin : g_msb
        assign sum[k] = w_s1[3*g][k] ^ w_s1[3*g+1][k] ^ w_s1[3*g+2][k];
      end
    end
    assign w_s2[2*g]   = sum;
    assign w_s2[2*g+1] = {cy, 1'b0};
  end

  for (genvar g = 0; g < 1; g++) begin : g_s3
    logic [PROD_W-1:0] sum;
    logic [PROD_W-2:0] cy;
    for (genvar k = 0; k < PROD_W; k++) begin : g_col
      if (k < PROD_W-1) begin : g_fa
        full_adder u_fa (
          .a    (w_s2[3*g][k]),
          .b    (w_s2[3*g+1][k]),
          .cin  (w_s2[3*g+2][k]),
          .sum  (sum[k]),
          .cout (cy[k])
        );
      end else begin : g_msb
        assign sum[k] = w_s2[3*g][k] ^ w_s2[3*g+1][k] ^ w_s2[3*g+2][k];
      end
    end
    assign w_s3[2*g]   = sum;
    assign w_s3[2*g+1] = {cy, 1'b0};
  end
  assign w_s3[2] = w_s2[3];

  for (genvar g = 0; g < 1; g++) begin : g_s4
    logic [PROD_W-1:0] sum;
    logic [PROD_W-2:0] cy;
    for (genvar k = 0; k < PROD_W; k++) begin : g_col
      if (k < PROD_W-1) begin : g_fa
        full_adder u_fa (
          .a    (w_s3[3*g][k]),
          .b    (w_s3[3*g+1][k]),
          .cin  (w_s3[3*g+2][k]),
          .sum  (sum[k]),
          .cout (cy[k])
        );
      end else begin : g_msb
        assign sum[k] = w_s3[3*g][k] ^ w_s3[3*g+1][k] ^ w_s3[3*g+2][k];
      end
    end
    assign w_s4[2*g]   = sum;
    assign w_s4[2*g+1] = {cy, 1'b0};
  end

  always_comb begin
    out0_d = w_s4[0] + w_s4[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_q <= '0;
    end else begin
      out0_q <= out0_d;
    end
  end

  assign out0 = out0_q;

endmodule

`default_nettype wire

// File: tb/tb_wt_8b.sv
//------------------------------------------------------------------------------
// Module  : tb_wt_8b
// Brief   : Scoreboard bench for the 8x8 Wallace-tree multiplier.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wt_8b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in0;
  logic [7:0]  in1;
  logic [15:0] out0;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q [$];
  bit          watch_en = 1'b0;
  bit          seen_bad = 1'b0;

  always #5 clk = ~clk;

  wt_8b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in0   (in0),
    .in1   (in1),
    .out0  (out0)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Operands launched at a negedge are captured at the following posedge.
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
    @(negedge clk);
    in0 = a;
    in1 = b;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1 && exp_q.size() > 0) begin
      check("product", out0, exp_q.pop_front());
    end
  end

  always @(out0) begin
    if (watch_en && out0 == 16'd40000) seen_bad = 1'b1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    in0   = 8'd255;
    in1   = 8'd255;
    #2 rst_n = 1'b0;
    #1 check("reset_async", out0, 16'h0000);
    repeat (3) begin
      @(posedge clk);
      #1 check("reset_hold", out0, 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(16'hFE01);

    drive(8'd0,   8'd173, 16'd0);
    drive(8'd1,   8'd200, 16'd200);
    drive(8'd255, 8'd1,   16'd255);
    drive(8'd128, 8'd2,   16'd256);
    drive(8'd15,  8'd17,  16'd255);
    drive(8'd16,  8'd16,  16'd256);
    drive(8'd170, 8'd85,  16'd14450);
    drive(8'd3,   8'd5,   16'd15);
    drive(8'd100, 8'd200, 16'd20000);
    drive(8'd255, 8'd254, 16'd64770);

    // Pending (200,200) is killed by reset before any edge can capture it.
    drive(8'd7, 8'd9, 16'd63);
    @(posedge clk);
    #2;
    in0      = 8'd200;
    in1      = 8'd200;
    watch_en = 1'b1;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1 check("async_rst_drop", out0, 16'h0000);
    @(posedge clk);
    #1 check("async_rst_hold", out0, 16'h0000);
    @(negedge clk);
    check("no_40000", {15'b0, seen_bad}, 16'h0000);
    watch_en = 1'b0;
    rst_n    = 1'b1;
    in0      = 8'd12;
    in1      = 8'd11;
    exp_q.push_back(16'd132);

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        drive(a[7:0], b[7:0], 16'(a * b));
      end
    end

    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge clk);
    #2;
    check("drain", 16'(exp_q.size()), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
